// File: rtl/reset_sequencer_if.sv
// Reset sequencer signal bundle: reset-request inputs plus staged reset outputs.
// master drives the requests and observes the resets; slave is the sequencer.
interface reset_sequencer_if;
   logic       nWD_RESET;
   logic       nCPU_RESET;
   logic       nRESET_VID;
   logic       nRESET_PERIPH;
   logic       nRESET_Z80;
   logic       nRESET_68K;
   logic       BUSY;
   logic [1:0] RST_CAUSE;
   logic [7:0] WD_COUNT;

   modport master (
      output nWD_RESET, nCPU_RESET,
      input  nRESET_VID, nRESET_PERIPH, nRESET_Z80, nRESET_68K,
      input  BUSY, RST_CAUSE, WD_COUNT
   );

   modport slave (
      input  nWD_RESET, nCPU_RESET,
      output nRESET_VID, nRESET_PERIPH, nRESET_Z80, nRESET_68K,
      output BUSY, RST_CAUSE, WD_COUNT
   );
endinterface

// File: rtl/reset_sequencer.sv
// Staged, glitch-filtered reset generator for the video, Z80, 68k and
// peripheral domains, driven by power-on, the watchdog and the 68k RESET
// instruction. Optional cause/watchdog-count tracking: RESET_SEQ_CAUSE_EN.
module reset_sequencer #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STAGE_GAP   = 8,
   parameter int unsigned FILTER_LEN  = 3
) (
   input  logic                CLK,
   input  logic                nRST,
   reset_sequencer_if.slave    rs
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned FILT_W = 4;

   localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(STAGE_GAP);
   localparam logic [FILT_W-1:0] FILT_THR = FILT_W'(FILTER_LEN);
   localparam logic [FILT_W-1:0] FILT_MAX = '1;

   typedef enum logic [2:0] {
      ST_ASSERT,
      ST_REL_VID,
      ST_REL_Z80,
      ST_RUN,
      ST_PERIPH
   } state_t;

   logic [1:0]        wd_sync_q, cpu_sync_q;
   logic [FILT_W-1:0] wd_filt_q, cpu_filt_q;
   logic [FILT_W-1:0] wd_filt_nxt, cpu_filt_nxt;
   logic              wd_qual, cpu_qual;

   state_t            state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic [4:0]        out_q;

   // {VID, PERIPH, Z80, 68K, BUSY} for a given state
   function automatic logic [4:0] decode(input state_t s);
      case (s)
         ST_REL_VID: decode = 5'b11001;
         ST_REL_Z80: decode = 5'b11101;
         ST_RUN:     decode = 5'b11110;
         ST_PERIPH:  decode = 5'b10011;
         default:    decode = 5'b00001;
      endcase
   endfunction

   // Two-flop synchronizers and low-run filter counters
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wd_sync_q  <= 2'b11;
         cpu_sync_q <= 2'b11;
         wd_filt_q  <= '0;
         cpu_filt_q <= '0;
      end else begin
         wd_sync_q  <= {wd_sync_q[0], rs.nWD_RESET};
         cpu_sync_q <= {cpu_sync_q[0], rs.nCPU_RESET};
         wd_filt_q  <= wd_filt_nxt;
         cpu_filt_q <= cpu_filt_nxt;
      end
   end

   // Filter next values; qualification uses the post-edge count so the
   // state machine reacts on the same edge the count reaches the threshold
   always_comb begin
      wd_filt_nxt  = wd_sync_q[1] ? '0 :
                     ((wd_filt_q == FILT_MAX) ? wd_filt_q : wd_filt_q + FILT_W'(1));
      cpu_filt_nxt = cpu_sync_q[1] ? '0 :
                     ((cpu_filt_q == FILT_MAX) ? cpu_filt_q : cpu_filt_q + FILT_W'(1));
      wd_qual      = (wd_filt_nxt >= FILT_THR);
      cpu_qual     = (cpu_filt_nxt >= FILT_THR);
   end

   // Next-state and shared stage counter; watchdog overrides everything
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         ST_ASSERT: begin
            if (wd_qual) begin
               cnt_nxt = HOLD_LD;
            end else if (cnt_q == '0) begin
               state_nxt = ST_REL_VID;
               cnt_nxt   = GAP_LD;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_REL_VID: begin
            if (cnt_q == '0) begin
               state_nxt = ST_REL_Z80;
               cnt_nxt   = GAP_LD;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_REL_Z80: begin
            if (cnt_q == '0) begin
               state_nxt = ST_RUN;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (cpu_qual) begin
               state_nxt = ST_PERIPH;
               cnt_nxt   = HOLD_LD;
            end
         end
         ST_PERIPH: begin
            if (cpu_qual) begin
               cnt_nxt = HOLD_LD;
            end else if (cnt_q == '0) begin
               state_nxt = ST_RUN;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_ASSERT;
            cnt_nxt   = HOLD_LD;
         end
      endcase
      if (wd_qual && (state_q != ST_ASSERT)) begin
         state_nxt = ST_ASSERT;
         cnt_nxt   = HOLD_LD;
      end
   end

   // State, counter and outputs update together on the same edge
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_ASSERT;
         cnt_q   <= HOLD_LD;
         out_q   <= 5'b00001;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         out_q   <= decode(state_nxt);
      end
   end

   assign rs.nRESET_VID    = out_q[4];
   assign rs.nRESET_PERIPH = out_q[3];
   assign rs.nRESET_Z80    = out_q[2];
   assign rs.nRESET_68K    = out_q[1];
   assign rs.BUSY          = out_q[0];

`ifdef RESET_SEQ_CAUSE_EN
   logic       wd_entry, cpu_entry;
   logic [1:0] cause_q;
   logic [7:0] wd_cnt_q;

   assign wd_entry  = wd_qual && (state_q != ST_ASSERT);
   assign cpu_entry = (state_q == ST_RUN) && cpu_qual && !wd_qual;

   // Last reset cause and saturating watchdog event count
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cause_q  <= 2'b00;
         wd_cnt_q <= '0;
      end else if (wd_entry) begin
         cause_q <= 2'b01;
         if (wd_cnt_q != 8'hFF) begin
            wd_cnt_q <= wd_cnt_q + 8'(1);
         end
      end else if (cpu_entry) begin
         cause_q <= 2'b10;
      end
   end

   assign rs.RST_CAUSE = cause_q;
   assign rs.WD_COUNT  = wd_cnt_q;
`else
   assign rs.RST_CAUSE = 2'b00;
   assign rs.WD_COUNT  = 8'h00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed scoreboard bench for reset_sequencer at default parameters.
// Cause/count expectations follow RESET_SEQ_CAUSE_EN.
module tb_reset_sequencer;

   localparam int HOLD  = 16;
   localparam int GAP   = 8;
   localparam int FL    = 3;
   localparam int T_FLT = 2 + FL;          // input fall to state change
   localparam int T_REL = 2 + HOLD + 1;    // input rise to first stage release
   localparam int T_SEQ = T_REL + 2 * (GAP + 1);

`ifdef RESET_SEQ_CAUSE_EN
   localparam bit CAUSE_EN = 1'b1;
`else
   localparam bit CAUSE_EN = 1'b0;
`endif

   typedef struct {
      string       tag;
      logic [14:0] v;
   } sb_t;

   logic CLK;
   logic nRST;
   reset_sequencer_if rs ();

   reset_sequencer #(
      .HOLD_CYCLES (HOLD),
      .STAGE_GAP   (GAP),
      .FILTER_LEN  (FL)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .rs   (rs)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   sb_t sb[$];
   int  n_cmp = 0;
   int  n_err = 0;

   // Expected {VID, PERIPH, Z80, 68K, BUSY, CAUSE, WD_COUNT}
   function automatic logic [14:0] mk(input bit vid, input bit per, input bit z80,
                                      input bit k68, input bit busy,
                                      input logic [1:0] cause, input logic [7:0] cnt);
      logic [1:0] c;
      logic [7:0] n;
      c = CAUSE_EN ? cause : 2'b00;
      n = CAUSE_EN ? cnt   : 8'h00;
      return {vid, per, z80, k68, busy, c, n};
   endfunction

   function automatic logic [14:0] v_low(input logic [1:0] c, input logic [7:0] n);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c, n);
   endfunction
   function automatic logic [14:0] v_vid(input logic [1:0] c, input logic [7:0] n);
      return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, c, n);
   endfunction
   function automatic logic [14:0] v_z80(input logic [1:0] c, input logic [7:0] n);
      return mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, c, n);
   endfunction
   function automatic logic [14:0] v_run(input logic [1:0] c, input logic [7:0] n);
      return mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, c, n);
   endfunction
   function automatic logic [14:0] v_per(input logic [1:0] c, input logic [7:0] n);
      return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c, n);
   endfunction

   task automatic wait_edges(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic compare();
      sb_t         e;
      logic [14:0] obs;
      obs = {rs.nRESET_VID, rs.nRESET_PERIPH, rs.nRESET_Z80, rs.nRESET_68K,
             rs.BUSY, rs.RST_CAUSE, rs.WD_COUNT};
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
         end
      end
   endtask

   // Queue expectation, advance n edges, then check DUT against queue head
   task automatic chk(input string tag, input int n, input logic [14:0] v);
      sb_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
      repeat (n) @(posedge CLK);
      #1;
      compare();
   endtask

   task automatic wd_event();
      rs.nWD_RESET = 1'b0;
      wait_edges(T_FLT);
      rs.nWD_RESET = 1'b1;
      wait_edges(T_REL);
   endtask

   initial begin
      rs.nWD_RESET  = 1'b1;
      rs.nCPU_RESET = 1'b1;
      nRST          = 1'b0;
      wait_edges(3);

      // Power-on sequencing
      chk("por_reset", 0, v_low(2'b00, 8'd0));
      nRST = 1'b1;
      chk("por_hold",    HOLD, v_low(2'b00, 8'd0));
      chk("por_vid",     1,    v_vid(2'b00, 8'd0));
      chk("por_vid_gap", GAP,  v_vid(2'b00, 8'd0));
      chk("por_z80",     1,    v_z80(2'b00, 8'd0));
      chk("por_z80_gap", GAP,  v_z80(2'b00, 8'd0));
      chk("por_run",     1,    v_run(2'b00, 8'd0));

      // Watchdog event held low for 100 cycles
      rs.nWD_RESET = 1'b0;
      chk("wd_pre",    T_FLT - 1, v_run(2'b00, 8'd0));
      chk("wd_assert", 1,         v_low(2'b01, 8'd1));
      wait_edges(100 - T_FLT);
      rs.nWD_RESET = 1'b1;
      chk("wd_hold", T_REL - 1, v_low(2'b01, 8'd1));
      chk("wd_vid",  1,         v_vid(2'b01, 8'd1));
      chk("wd_z80",  GAP + 1,   v_z80(2'b01, 8'd1));
      chk("wd_run",  GAP + 1,   v_run(2'b01, 8'd1));

      // Two-cycle glitches on both inputs
      rs.nWD_RESET  = 1'b0;
      rs.nCPU_RESET = 1'b0;
      wait_edges(2);
      rs.nWD_RESET  = 1'b1;
      rs.nCPU_RESET = 1'b1;
      chk("glitch_a", 2, v_run(2'b01, 8'd1));
      chk("glitch_b", 6, v_run(2'b01, 8'd1));

      // CPU reset instruction, 10 cycles low
      rs.nCPU_RESET = 1'b0;
      chk("cpu_pre",    T_FLT - 1, v_run(2'b01, 8'd1));
      chk("cpu_periph", 1,         v_per(2'b10, 8'd1));
      wait_edges(10 - T_FLT);
      rs.nCPU_RESET = 1'b1;
      chk("cpu_hold", T_REL - 1, v_per(2'b10, 8'd1));
      chk("cpu_run",  1,         v_run(2'b10, 8'd1));

      // Simultaneous fall: watchdog wins
      rs.nWD_RESET  = 1'b0;
      rs.nCPU_RESET = 1'b0;
      chk("prio_both", T_FLT, v_low(2'b01, 8'd2));
      wait_edges(1);
      rs.nWD_RESET  = 1'b1;
      rs.nCPU_RESET = 1'b1;
      chk("prio_run", T_SEQ, v_run(2'b01, 8'd2));

      // Watchdog during PERIPH
      rs.nCPU_RESET = 1'b0;
      chk("prio_periph", T_FLT, v_per(2'b10, 8'd2));
      rs.nWD_RESET = 1'b0;
      chk("prio_pre", T_FLT - 1, v_per(2'b10, 8'd2));
      chk("prio_wd",  1,         v_low(2'b01, 8'd3));
      rs.nWD_RESET  = 1'b1;
      rs.nCPU_RESET = 1'b1;
      chk("prio_run2", T_SEQ, v_run(2'b01, 8'd3));

      // nRST from RUN, then again mid-REL_Z80
      nRST = 1'b0;
      chk("rst_async", 0, v_low(2'b00, 8'd0));
      wait_edges(1);
      nRST = 1'b1;
      chk("rst_relz80", 30, v_z80(2'b00, 8'd0));
      nRST = 1'b0;
      chk("rst_mid", 0, v_low(2'b00, 8'd0));
      wait_edges(2);
      nRST = 1'b1;
      chk("rst_hold", HOLD,        v_low(2'b00, 8'd0));
      chk("rst_vid",  1,           v_vid(2'b00, 8'd0));
      chk("rst_run",  2 * GAP + 2, v_run(2'b00, 8'd0));

      // Watchdog count saturation over 260 events
      for (int i = 0; i < 254; i++) wd_event();
      chk("sat_254", 0, v_vid(2'b01, 8'd254));
      wd_event();
      chk("sat_255", 0, v_vid(2'b01, 8'd255));
      for (int i = 0; i < 5; i++) wd_event();
      chk("sat_260", 0,           v_vid(2'b01, 8'd255));
      chk("sat_run", 2 * GAP + 2, v_run(2'b01, 8'd255));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
